// File: rtl/alu_md.sv
// alu_md: EX-stage integer ALU with an iterative multiply/divide unit.
//
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   A, B          operands (rs, rt/imm)
//   ALUOp         combinational op select: 0 add, 1 sub, 2 and, 3 or,
//                 4 srl, 5 sra, 6 slt, 7 sltu (shift amount is B[SHW-1:0])
//   C             combinational ALU result, independent of the md unit
//   md_op         0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op
//   start         request md_op this cycle
//   busy          iterative mult/div in progress
//   done          one-cycle pulse in the cycle hi/lo show a new result
//   div_by_zero   one-cycle pulse with done for div/divu when B == 0
//   hi, lo        HI/LO result registers
//
// Handshake: start is accepted at a rising edge whenever the unit is not
// busy (including the cycle in which done is high); start while busy is
// dropped, not queued. A mult/div raises busy for exactly WIDTH cycles
// after the accepting edge; busy falls in the same cycle done rises, so
// done appears in cycle WIDTH+2 counting the start cycle as cycle 1.
// mthi/mtlo and divide-by-zero finish with done in the very next cycle
// and never raise busy. md_op 6/7 produce nothing.
module alu_md #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOp,
  output logic [WIDTH-1:0] C,
  input  logic [2:0]       md_op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // ---------------------------------------------------------------------
  // Combinational ALU
  // ---------------------------------------------------------------------
  logic lt_s;
  logic lt_u;

  assign lt_s = $signed(A) < $signed(B);
  assign lt_u = A < B;

  always_comb begin
    C = '0;
    case (ALUOp)
      3'd0:    C = A + B;
      3'd1:    C = A - B;
      3'd2:    C = A & B;
      3'd3:    C = A | B;
      3'd4:    C = A >> B[SHW-1:0];
      3'd5:    C = $signed(A) >>> B[SHW-1:0];
      3'd6:    C = {{(WIDTH-1){1'b0}}, lt_s};
      3'd7:    C = {{(WIDTH-1){1'b0}}, lt_u};
      default: C = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Multiply / divide unit
  // ---------------------------------------------------------------------
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam logic [SHW:0] COUNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] COUNT_LAST = (SHW+1)'(1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t               state;
  // acc holds {partial product, multiplier} during MUL and
  // {partial remainder, dividend/quotient} during DIV.
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opb;      // multiplicand or divisor magnitude
  logic                 neg_lo;   // negate product / quotient at the end
  logic                 neg_hi;   // negate remainder at the end
  logic [SHW:0]         count;

  // Operand magnitudes and sign flags for the op being requested.
  logic                 signed_op;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;

  assign signed_op = (md_op == MD_MULT) || (md_op == MD_DIV);
  assign a_neg     = signed_op & A[WIDTH-1];
  assign b_neg     = signed_op & B[WIDTH-1];
  assign a_mag     = a_neg ? -A : A;
  assign b_mag     = b_neg ? -B : B;

  // One iteration of shift-add multiply or restoring divide.
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_trial;
  logic [2*WIDTH-1:0]   acc_nxt;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_trial = div_shift - {1'b0, opb};
    if (state == MUL) begin
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end else if (div_trial[WIDTH]) begin
      // Trial went negative: keep the shifted remainder, quotient bit 0.
      acc_nxt = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  // Sign correction applied to the final iteration's result, so hi/lo
  // are written on the same edge that enters FIN.
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  assign prod_fix = neg_lo ? -acc_nxt : acc_nxt;
  assign quo_fix  = neg_lo ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
  assign rem_fix  = neg_hi ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      acc         <= '0;
      opb         <= '0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      count       <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        // FIN is the done cycle; it accepts a new start just like IDLE.
        IDLE, FIN: begin
          state <= IDLE;
          if (start) begin
            case (md_op)
              MD_MULT, MD_MULTU: begin
                state  <= MUL;
                busy   <= 1'b1;
                acc    <= {{WIDTH{1'b0}}, b_mag};
                opb    <= a_mag;
                neg_lo <= a_neg ^ b_neg;
                neg_hi <= 1'b0;
                count  <= COUNT_INIT;
              end
              MD_DIV, MD_DIVU: begin
                if (B == '0) begin
                  done        <= 1'b1;
                  div_by_zero <= 1'b1;
                end else begin
                  state  <= DIV;
                  busy   <= 1'b1;
                  acc    <= {{WIDTH{1'b0}}, a_mag};
                  opb    <= b_mag;
                  neg_lo <= a_neg ^ b_neg;
                  neg_hi <= a_neg;
                  count  <= COUNT_INIT;
                end
              end
              MD_MTHI: begin
                hi   <= A;
                done <= 1'b1;
              end
              MD_MTLO: begin
                lo   <= A;
                done <= 1'b1;
              end
              default: begin
              end
            endcase
          end
        end
        MUL, DIV: begin
          acc   <= acc_nxt;
          count <= count - 1'b1;
          if (count == COUNT_LAST) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (state == MUL) begin
              {hi, lo} <= prod_fix;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md.sv
module tb_alu_md;

  localparam int W = 32;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [2:0]   ALUOp = '0;
  logic [W-1:0] C;
  logic [2:0]   md_op = '0;
  logic         start = 1'b0;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  always #5 clk = ~clk;

  alu_md #(.WIDTH(W), .SHW(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .A           (A),
    .B           (B),
    .ALUOp       (ALUOp),
    .C           (C),
    .md_op       (md_op),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  int checks = 0;
  int failures = 0;

  // Reference HI/LO contents.
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference models (plain arithmetic)
  // ---------------------------------------------------------------------
  function automatic logic [W-1:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sb, p, q;
    longint unsigned ua;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    sh = int'(b[4:0]);
    p  = longint'(1) << sh;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: begin
        ua = ua / longint'(p);
        return ua[31:0];
      end
      3'd5: begin
        // Arithmetic shift is floor division by 2**sh.
        q = sa / p;
        if ((sa % p != 0) && (sa < 0)) q = q - 1;
        return q[31:0];
      end
      3'd6: return (sa < sb) ? 32'd1 : 32'd0;
      default: return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  // Counts negedges after the accepting edge until done is seen (bounded),
  // and how many of those cycles had busy high. Operand inputs are
  // scrambled meanwhile to show they were latched.
  task automatic wait_done(output int k, output int busy_n);
    k = 0;
    busy_n = 0;
    while (!done && k < W + 8) begin
      if (busy) busy_n++;
      @(negedge clk);
      A = $urandom;
      B = $urandom;
      k++;
    end
  endtask

  task automatic run_md(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    logic [63:0] p;
    longint q, r;
    logic [W-1:0] eh, el;
    logic exp_done, exp_dz;
    int exp_k, k, busy_n;
    eh = model_hi;
    el = model_lo;
    exp_done = 1'b1;
    exp_dz = 1'b0;
    exp_k = W;
    case (op)
      3'd0: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        eh = p[63:32]; el = p[31:0];
      end
      3'd1: begin
        p = {32'd0, a} * {32'd0, b};
        eh = p[63:32]; el = p[31:0];
      end
      3'd2: begin
        if (b == '0) begin
          exp_dz = 1'b1; exp_k = 0;
        end else begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          el = q[31:0]; eh = r[31:0];
        end
      end
      3'd3: begin
        if (b == '0) begin
          exp_dz = 1'b1; exp_k = 0;
        end else begin
          el = a / b; eh = a % b;
        end
      end
      3'd4: begin eh = a; exp_k = 0; end
      3'd5: begin el = a; exp_k = 0; end
      default: exp_done = 1'b0;
    endcase
    @(negedge clk);
    A = a; B = b; md_op = op; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(k, busy_n);
    if (exp_done) begin
      check({tag, " latency"}, 64'(k), 64'(exp_k));
      check({tag, " busy_cycles"}, 64'(busy_n), 64'(exp_k));
      check({tag, " busy_at_done"}, 64'(busy), 64'd0);
      check({tag, " dz"}, 64'(div_by_zero), 64'(exp_dz));
      check({tag, " hi"}, 64'(hi), 64'(eh));
      check({tag, " lo"}, 64'(lo), 64'(el));
      @(negedge clk);
      check({tag, " done_pulse"}, 64'(done), 64'd0);
    end else begin
      check({tag, " no_done"}, 64'(done), 64'd0);
      check({tag, " hi_hold"}, 64'(hi), 64'(eh));
      check({tag, " lo_hold"}, 64'(lo), 64'(el));
    end
    model_hi = eh;
    model_lo = el;
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  logic [W-1:0] sweep_exp [8] = '{32'h8000_0005, 32'h7FFF_FFFB, 32'h0, 32'h8000_0005,
                                  32'h0400_0000, 32'hFC00_0000, 32'h1, 32'h0};

  initial begin
    int k, busy_n, dn, dk;
    logic [W-1:0] ra, rb;
    logic [2:0] rop;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU sweep from the directed table
    A = 32'h8000_0000;
    B = 32'd5;
    for (int i = 0; i < 8; i++) begin
      ALUOp = 3'(i);
      #1;
      check($sformatf("alu_sweep_op%0d", i), 64'(C), 64'(sweep_exp[i]));
    end
    A = 32'hFFFF_FFFF; B = 32'd0;
    ALUOp = 3'd6; #1; check("alu_slt_m1", 64'(C), 64'd1);
    ALUOp = 3'd7; #1; check("alu_sltu_m1", 64'(C), 64'd0);

    // Random ALU vectors, including while the md unit is idle
    for (int i = 0; i < 40; i++) begin
      A = $urandom;
      B = (i % 4 == 0) ? A : $urandom;
      ALUOp = 3'($urandom_range(0, 7));
      #1;
      check($sformatf("alu_rand op=%0d a=%h b=%h", ALUOp, A, B), 64'(C),
            64'(alu_ref(ALUOp, A, B)));
    end

    // Directed multiply / divide
    run_md("mult_m3x7", 3'd0, 32'hFFFF_FFFD, 32'd7);
    run_md("multu_max_x2", 3'd1, 32'hFFFF_FFFF, 32'd2);
    run_md("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2);
    run_md("divu_100_7", 3'd3, 32'd100, 32'd7);
    run_md("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_min_m1_lo_const", 64'(lo), 64'h8000_0000);

    // Divide by zero keeps hi/lo
    run_md("mthi", 3'd4, 32'h11, 32'd0);
    run_md("mtlo", 3'd5, 32'h22, 32'd0);
    run_md("div_5_0", 3'd2, 32'd5, 32'd0);
    check("dz_hi_const", 64'(hi), 64'h11);
    check("dz_lo_const", 64'(lo), 64'h22);
    run_md("noop6", 3'd6, 32'h1234, 32'h5678);

    // Random md operations
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_md($sformatf("md_rand%0d op=%0d", i, rop), rop, ra, rb);
    end

    // Start while busy is ignored: one done, first result only
    model_hi = 32'hFFFF_FFFF;
    model_lo = 32'hFFFF_FFD3;      // -5 * 9 = -45
    @(negedge clk);
    A = 32'hFFFF_FFFB; B = 32'd9; md_op = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dn = 0; dk = -1;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        dn++;
        if (dk < 0) dk = i;
      end
      if (i == 5) begin A = 32'd2; B = 32'd3; md_op = 3'd0; start = 1'b1; end
      if (i == 6) start = 1'b0;
      @(negedge clk);
    end
    check("busy_start done_count", 64'(dn), 64'd1);
    check("busy_start latency", 64'(dk), 64'(W));
    check("busy_start hi", 64'(hi), 64'(model_hi));
    check("busy_start lo", 64'(lo), 64'(model_lo));

    // Start in the done cycle is accepted
    @(negedge clk);
    A = 32'd3; B = 32'd3; md_op = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(k, busy_n);
    check("b2b first latency", 64'(k), 64'(W));
    check("b2b first lo", 64'(lo), 64'd9);
    A = 32'd4; B = 32'd5; md_op = 3'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(k, busy_n);
    check("b2b second latency", 64'(k), 64'(W));
    check("b2b second hi", 64'(hi), 64'd0);
    check("b2b second lo", 64'(lo), 64'd20);
    model_hi = 32'd0;
    model_lo = 32'd20;

    // Asynchronous reset mid-divide
    @(negedge clk);
    A = 32'd1000; B = 32'd3; md_op = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst busy", 64'(busy), 64'd0);
    check("async_rst done", 64'(done), 64'd0);
    check("async_rst hi", 64'(hi), 64'd0);
    check("async_rst lo", 64'(lo), 64'd0);
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("post_rst no_done", 64'(dn), 64'd0);
    run_md("post_rst mult_6x7", 3'd0, 32'd6, 32'd7);
    check("post_rst lo_const", 64'(lo), 64'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

endmodule
